uart_tx: RTL

UART transmitter that serializes bytes onto the `io_tx` pin using 8N1 framing: one start bit, eight data bits LSB-first, one stop bit, no parity. It is the transmit-side counterpart of the `io_rx` program-load/receive path in `cpu`. Bytes enter through a valid/ready handshake into a small internal FIFO, so the core or a memory-mapped I/O port can post several bytes without stalling. It is instantiated next to `cpu`, and `io_tx` is brought out to the top level.

---
 rtl/common_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared types and constants for the UART transmit path.
package common;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int unsigned UART_CLKS_PER_BIT = 868;
  localparam int unsigned UART_FIFO_DEPTH   = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter; pointers carry an extra wrap bit.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   wr_data,
  input  logic                         pop,
  output logic [7:0]                   rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] diff;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign diff    = wr_ptr - rd_ptr;
  assign count   = CW'(diff);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update; reset discards anything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and back-to-back framing.
module uart_tx
  import common::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              io_tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           io_tx_d;
  logic           pop;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_head;
  logic           bit_end;

  assign tx_ready = !fifo_full && !reset;
  assign push     = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign bit_end  = (baud_q == BAUD_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (tx_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state, line level and datapath updates for the framing FSM.
  always_comb begin
    state_d = state_q;
    io_tx_d = io_tx;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        io_tx_d = 1'b1;
        baud_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          io_tx_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          io_tx_d = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            io_tx_d = 1'b1;
            state_d = STOP;
          end else begin
            io_tx_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = fifo_head;
            io_tx_d = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        io_tx_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset truncates any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      io_tx   <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      io_tx   <= io_tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule
